regwe_decoder: RTL and testbench

Parametrised, registered write-enable decoder for the register file. Converts up to `PORTS` simultaneous write requests (binary address + enable) into a one-hot-union write-enable vector over `2**ADDR_W` registers. Resolves same-address conflicts by fixed priority and counts them. Also provides a sequential clear sweep that walks every register once, for the reset-time register-file clear.

---
 rtl/regwe_decoder.sv | 143 ++++++++++++++
 tb/tb_regwe_decoder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regwe_decoder.sv
// regwe_decoder: registered multi-port write-enable decoder for the register file.
// Resolves same-address port collisions by fixed priority (port 0 wins) and counts
// the collision cycles. It also runs a one-register-per-cycle clear sweep.
// Optional feature macro: REGWE_ZERO_LOCK_EN. When it is defined, register 0 is
// hardwired and never receives a write enable.

// Per-port decode: decides whether this port wins priority, and produces its one-hot.
module regwe_port #(
  parameter int ADDR_W = 5,
  parameter int PORTS  = 2,
  parameter int IDX    = 0
) (
  input  logic [PORTS-1:0]             valid,
  input  logic [PORTS-1:0][ADDR_W-1:0] addr,
  output logic                         win,
  output logic [(2**ADDR_W)-1:0]       hot
);
  localparam int DEPTH = 2**ADDR_W;

  // A port loses when any higher-priority (lower index) valid port targets its address.
  always_comb begin
    win = valid[IDX];
    for (int q = 0; q < IDX; q++)
      if (valid[q] && (addr[q] == addr[IDX])) win = 1'b0;
    hot = win ? (DEPTH'(1) << addr[IDX]) : '0;
  end
endmodule

module regwe_decoder #(
  parameter int ADDR_W = 5,
  parameter int PORTS  = 2,
  parameter int CNT_W  = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [PORTS-1:0]          wr_en,
  input  logic [PORTS*ADDR_W-1:0]   wr_addr,
  input  logic                      clear_req,
  output logic [(2**ADDR_W)-1:0]    we_out,
  output logic [PORTS-1:0]          grant,
  output logic                      conflict,
  output logic [CNT_W-1:0]          conflict_cnt,
  output logic                      busy,
  output logic                      clear_done
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH-1);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t                      state;
  logic [ADDR_W:0]             sweep_idx;  // one extra bit so the terminal compare never wraps
  logic [PORTS-1:0][ADDR_W-1:0] addr_v;
  logic [PORTS-1:0]            valid;
  logic [PORTS-1:0]            win;
  logic [PORTS-1:0][DEPTH-1:0] hot;
  logic [DEPTH-1:0]            dec_we;
  logic                        dec_conflict;
  logic [DEPTH-1:0]            sweep_hot;

  assign addr_v = wr_addr;

  genvar p;
  generate
    for (p = 0; p < PORTS; p++) begin : g_port
`ifdef REGWE_ZERO_LOCK_EN
      // An address-0 request is treated as if the port were idle.
      assign valid[p] = wr_en[p] && (addr_v[p] != '0);
`else
      assign valid[p] = wr_en[p];
`endif
      regwe_port #(.ADDR_W(ADDR_W), .PORTS(PORTS), .IDX(p)) u_port (
        .valid (valid),
        .addr  (addr_v),
        .win   (win[p]),
        .hot   (hot[p])
      );
    end
  endgenerate

  // Merge the winning ports' one-hots and flag any valid port that lost.
  always_comb begin
    dec_we = '0;
    for (int i = 0; i < PORTS; i++) dec_we |= hot[i];
    dec_conflict = |(valid & ~win);
  end

  // Sweep enable for the current index. Bit 0 stays masked when register 0 is locked.
  always_comb begin
    sweep_hot = DEPTH'(1) << sweep_idx[ADDR_W-1:0];
`ifdef REGWE_ZERO_LOCK_EN
    sweep_hot[0] = 1'b0;
`endif
  end

  // Control FSM. Every output is registered here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      sweep_idx    <= '0;
      we_out       <= '0;
      grant        <= '0;
      conflict     <= 1'b0;
      conflict_cnt <= '0;
      busy         <= 1'b0;
      clear_done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          we_out     <= dec_we;
          grant      <= win;
          conflict   <= dec_conflict;
          busy       <= 1'b0;
          clear_done <= 1'b0;
          if (dec_conflict && (conflict_cnt != '1))
            conflict_cnt <= conflict_cnt + CNT_W'(1);
          if (clear_req) begin
            state     <= SWEEP;
            sweep_idx <= '0;
          end
        end
        SWEEP: begin
          we_out     <= sweep_hot;
          grant      <= '0;
          conflict   <= 1'b0;
          busy       <= 1'b1;
          clear_done <= 1'b0;
          sweep_idx  <= sweep_idx + (ADDR_W+1)'(1);
          if (sweep_idx == LAST_IDX) state <= DONE;
        end
        DONE: begin
          we_out     <= '0;
          grant      <= '0;
          conflict   <= 1'b0;
          busy       <= 1'b0;
          clear_done <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regwe_decoder.sv
// Testbench for regwe_decoder: fixed scenarios plus randomized traffic, checked
// against a set-based reference model of the port priority rules.
module tb_regwe_decoder;
  localparam int AW    = 5;
  localparam int NP    = 2;
  localparam int CW    = 8;
  localparam int DEPTH = 1 << AW;
  localparam int CMAX  = (1 << CW) - 1;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NP-1:0]     wr_en = '0;
  logic [NP*AW-1:0]  wr_addr = '0;
  logic              clear_req = 1'b0;
  logic [DEPTH-1:0]  we_out;
  logic [NP-1:0]     grant;
  logic              conflict;
  logic [CW-1:0]     conflict_cnt;
  logic              busy;
  logic              clear_done;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;

  regwe_decoder #(.ADDR_W(AW), .PORTS(NP), .CNT_W(CW)) dut (
    .clock        (clock),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .clear_req    (clear_req),
    .we_out       (we_out),
    .grant        (grant),
    .conflict     (conflict),
    .conflict_cnt (conflict_cnt),
    .busy         (busy),
    .clear_done   (clear_done)
  );

  always #5 clock = ~clock;

  // Reference model: walk the ports in priority order and keep a set of claimed addresses.
  function automatic void model(input logic [NP-1:0] en, input logic [NP*AW-1:0] ad,
                                output logic [DEPTH-1:0] we, output logic [NP-1:0] gr,
                                output logic cf);
    bit seen [int];
    logic [DEPTH-1:0] one;
    int a;
    one = 1;
    we = '0; gr = '0; cf = 1'b0;
    for (int p = 0; p < NP; p++) begin
      a = int'(ad[p*AW +: AW]);
      if (en[p]) begin
`ifdef REGWE_ZERO_LOCK_EN
        if (a != 0) begin
`else
        begin
`endif
          if (seen.exists(a)) cf = 1'b1;
          else begin
            seen[a] = 1'b1;
            gr[p] = 1'b1;
            we = we | (one << a);
          end
        end
      end
    end
  endfunction

  function automatic logic [DEPTH-1:0] sweep_exp(input int k);
    logic [DEPTH-1:0] v;
    v = 1;
    v = v << k;
`ifdef REGWE_ZERO_LOCK_EN
    v[0] = 1'b0;
`endif
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ports(input logic [NP-1:0] en, input int a0, input int a1);
    wr_en = en;
    wr_addr[0 +: AW]  = AW'(a0);
    wr_addr[AW +: AW] = AW'(a1);
  endtask

  task automatic rand_ports(input bit narrow);
    wr_en = NP'($urandom);
    for (int p = 0; p < NP; p++)
      wr_addr[p*AW +: AW] = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rand_ports(1'b0);
    clear_req = 1'b1;
    tick();
    tick();
    checks++;
    if ({we_out, grant, conflict, conflict_cnt, busy, clear_done} !== '0) begin
      failures++;
      $display("FAIL reset_state: we=%h grant=%b conf=%b cnt=%0d busy=%b done=%b, all required 0",
               we_out, grant, conflict, conflict_cnt, busy, clear_done);
    end
    reset = 1'b0;
    clear_req = 1'b0;
    set_ports('0, 0, 0);
    exp_cnt = 0;
  endtask

  task automatic test_single_port();
    set_ports(2'b01, 7, 0);
    tick();
    checks++;
    if (we_out !== 32'h0000_0080) begin
      failures++; $display("FAIL single_we: got %h want 00000080", we_out);
    end
    checks++;
    if (grant !== 2'b01 || conflict !== 1'b0) begin
      failures++; $display("FAIL single_grant: got grant=%b conf=%b want 01/0", grant, conflict);
    end
  endtask

  task automatic test_disjoint();
    set_ports(2'b11, 3, 30);
    tick();
    checks++;
    if (we_out !== 32'h4000_0008 || grant !== 2'b11 || conflict !== 1'b0) begin
      failures++;
      $display("FAIL disjoint: got we=%h grant=%b conf=%b want 40000008/11/0", we_out, grant, conflict);
    end
  endtask

  task automatic test_collision();
    do_reset();
    set_ports(2'b11, 12, 12);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (we_out !== 32'h0000_1000 || grant !== 2'b01 || conflict !== 1'b1) begin
        failures++;
        $display("FAIL collision_cyc%0d: got we=%h grant=%b conf=%b want 00001000/01/1",
                 i, we_out, grant, conflict);
      end
    end
    exp_cnt = 3;
    set_ports('0, 0, 0);
    tick();
    checks++;
    if (conflict !== 1'b0 || conflict_cnt !== CW'(3)) begin
      failures++; $display("FAIL collision_cnt: got conf=%b cnt=%0d want 0/3", conflict, conflict_cnt);
    end
  endtask

  task automatic test_zero_addr();
    logic [DEPTH-1:0] ew; logic [NP-1:0] eg; logic ec;
    set_ports(2'b11, 0, 0);
    model(wr_en, wr_addr, ew, eg, ec);
    if (ec && exp_cnt < CMAX) exp_cnt++;
    tick();
    checks++;
    if (we_out !== ew || grant !== eg || conflict !== ec || conflict_cnt !== CW'(exp_cnt)) begin
      failures++;
      $display("FAIL zero_addr: got we=%h grant=%b conf=%b cnt=%0d want %h/%b/%b/%0d",
               we_out, grant, conflict, conflict_cnt, ew, eg, ec, exp_cnt);
    end
  endtask

  task automatic test_random();
    logic [DEPTH-1:0] ew; logic [NP-1:0] eg; logic ec;
    for (int i = 0; i < 300; i++) begin
      rand_ports(($urandom % 2) == 0);
      model(wr_en, wr_addr, ew, eg, ec);
      if (ec && exp_cnt < CMAX) exp_cnt++;
      tick();
      checks++;
      if (we_out !== ew || grant !== eg || conflict !== ec || conflict_cnt !== CW'(exp_cnt) || busy !== 1'b0) begin
        failures++;
        $display("FAIL random_%0d: got we=%h grant=%b conf=%b cnt=%0d busy=%b want %h/%b/%b/%0d/0",
                 i, we_out, grant, conflict, conflict_cnt, busy, ew, eg, ec, exp_cnt);
      end
    end
    set_ports('0, 0, 0);
  endtask

  task automatic test_sweep();
    logic [DEPTH-1:0] ew; logic [NP-1:0] eg; logic ec;
    // The request sampled with clear_req is decoded before the sweep starts.
    clear_req = 1'b1;
    set_ports(2'b01, 5, 0);
    tick();
    checks++;
    if (we_out !== 32'h0000_0020 || grant !== 2'b01 || busy !== 1'b0) begin
      failures++; $display("FAIL sweep_first: got we=%h grant=%b busy=%b want 00000020/01/0", we_out, grant, busy);
    end
    for (int k = 0; k < DEPTH; k++) begin
      clear_req = 1'($urandom);
      rand_ports(1'b1);
      tick();
      checks++;
      if (we_out !== sweep_exp(k) || busy !== 1'b1 || grant !== '0 || conflict !== 1'b0 || clear_done !== 1'b0) begin
        failures++;
        $display("FAIL sweep_k%0d: got we=%h busy=%b grant=%b conf=%b done=%b want %h/1/0/0/0",
                 k, we_out, busy, grant, conflict, clear_done, sweep_exp(k));
      end
    end
    clear_req = 1'b1;
    set_ports(2'b11, 4, 4);
    tick();
    checks++;
    if (clear_done !== 1'b1 || busy !== 1'b0 || we_out !== '0 || grant !== '0 || conflict_cnt !== CW'(exp_cnt)) begin
      failures++;
      $display("FAIL sweep_done: got done=%b busy=%b we=%h grant=%b cnt=%0d want 1/0/0/0/%0d",
               clear_done, busy, we_out, grant, conflict_cnt, exp_cnt);
    end
    clear_req = 1'b0;
    set_ports(2'b10, 0, 9);
    model(wr_en, wr_addr, ew, eg, ec);
    tick();
    checks++;
    if (we_out !== ew || grant !== eg || clear_done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL sweep_resume: got we=%h grant=%b done=%b busy=%b want %h/%b/0/0",
               we_out, grant, clear_done, busy, ew, eg);
    end
    set_ports('0, 0, 0);
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL sweep_no_restart: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid_sweep();
    bit bad;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    checks++;
    if (busy !== 1'b1 || we_out !== sweep_exp(9)) begin
      failures++; $display("FAIL midsweep_pre: got busy=%b we=%h want 1/%h", busy, we_out, sweep_exp(9));
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_cnt = 0;
    checks++;
    if ({we_out, grant, conflict, conflict_cnt, busy, clear_done} !== '0) begin
      failures++;
      $display("FAIL midsweep_reset: we=%h grant=%b conf=%b cnt=%0d busy=%b done=%b, all required 0",
               we_out, grant, conflict, conflict_cnt, busy, clear_done);
    end
    set_ports(2'b01, 2, 0);
    tick();
    checks++;
    if (we_out !== 32'h0000_0004 || grant !== 2'b01) begin
      failures++; $display("FAIL midsweep_write: got we=%h grant=%b want 00000004/01", we_out, grant);
    end
    set_ports('0, 0, 0);
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (clear_done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++; $display("FAIL midsweep_no_done: stray busy/clear_done after reset, required none");
    end
  endtask

  task automatic test_saturation();
    do_reset();
    set_ports(2'b11, 12, 12);
    for (int i = 0; i < CMAX + 5; i++) tick();
    set_ports('0, 0, 0);
    tick();
    checks++;
    if (conflict_cnt !== 8'hFF) begin
      failures++; $display("FAIL saturation: got cnt=%0d want 255", conflict_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_port();
    test_disjoint();
    test_collision();
    test_zero_addr();
    test_random();
    test_sweep();
    test_reset_mid_sweep();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
